// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity mode
// encodings, transmit FSM state type and baud divisor helper.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Clocks per serial bit; integer truncation of the ratio.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_param_baud.sv
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
// enabled, strobes bit_end_o on the last count and wraps; held at zero when
// disabled so every frame starts on a full bit period.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic bit_end_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: advance while enabled, wrap at the bit boundary, clear when idle.
   always_comb begin
      cnt_d = '0;
      if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity and stop
// bits, valid/ready input handshake, registered outputs.
// Optional activity LED stretcher enabled by defining UART_TX_LED_EN.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ        = 100_000_000,
   parameter int unsigned BAUD_RATE       = 9600,
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned PARITY          = 1,
   parameter int unsigned STOP_BITS       = 1,
   parameter int unsigned LED_HOLD_CYCLES = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
`ifdef UART_TX_LED_EN
   ,
   output logic                 led
`endif
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam logic [3:0]  LAST_DATA    = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP    = 4'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (PARITY > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (LED_HOLD_CYCLES < 1) begin : g_bad_led
      $error("uart_tx_param: LED_HOLD_CYCLES must be at least 1");
   end

   tx_state_t            state_q, state_d;
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           idx_q, idx_d;
   logic                 par_q, par_d;
   logic                 bit_end;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .en_i     (state_q != IDLE),
      .bit_end_o(bit_end)
   );

   // Frame sequencing. The line value for the next bit is decided one bit
   // boundary ahead so tx stays registered; idx_q counts data bits in DATA
   // and is reused to count stop bits in STOP.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shift_d = shift_q;
      idx_d   = idx_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (tx_valid && ready_q) begin
               state_d = START;
               tx_d    = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               shift_d = tx_data;
               par_d   = (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_DATA) begin
                  idx_d = '0;
                  if (PARITY != PARITY_NONE) begin
                     state_d = uart_pkg::PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 4'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (idx_q == LAST_STOP) begin
                  idx_d   = '0;
                  state_d = IDLE;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and output registers; reset forces the line idle at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         shift_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

`ifdef UART_TX_LED_EN
   localparam int unsigned LED_W = $clog2(LED_HOLD_CYCLES + 1);

   logic [LED_W-1:0] led_cnt_q, led_cnt_d;
   logic             led_q;

   // LED hold counter: (re)load on every done pulse, then count down to zero.
   always_comb begin
      led_cnt_d = led_cnt_q;
      if (done_q) begin
         led_cnt_d = LED_W'(LED_HOLD_CYCLES);
      end else if (led_cnt_q != '0) begin
         led_cnt_d = led_cnt_q - LED_W'(1);
      end
   end

   // LED registers; led tracks the next counter value so it is itself a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_cnt_q <= '0;
         led_q     <= 1'b0;
      end else begin
         led_cnt_q <= led_cnt_d;
         led_q     <= (led_cnt_d != '0);
      end
   end

   assign led = led_q;
`endif

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8-data-bit, even-parity, 1-stop transmitter.
- Configurable data width, parity mode, stop-bit count and baud rate.
- valid/ready input handshake, asynchronous active-low reset, optional LED activity stretcher.
- Sits between a byte/word producer (FIFO or command engine) and the board TX pin.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUD_RATE, 9600: line rate in bit/s. Localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer truncation). CLKS_PER_BIT < 2 is an elaboration error.
- DATA_BITS, 8: payload width, legal range 5..9. Other values are an elaboration error.
- PARITY, 1: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal values 1 or 2.
- LED_HOLD_CYCLES, 5_000_000: LED on-time in clocks. Used only with UART_TX_LED_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  producer has a word.
- tx_data  in  DATA_BITS  word to send, sampled only on handshake.
- tx_ready  out  1  block can accept a word.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at end of frame.
- led  out  1  activity LED. Present only with UART_TX_LED_EN.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous assert, synchronous release, active-low. Every register resets asynchronously.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, led=0. FSM state IDLE, baud counter 0, bit index 0.
- All outputs are registered.
- Handshake: a word is accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into a shift register on acceptance; later changes to tx_data are ignored.
  - tx_valid while not ready is ignored; nothing is queued.
- FSM states:
  - IDLE: tx=1. On accept, go to START.
  - START: tx=0 for CLKS_PER_BIT clocks.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT clocks.
  - PARITY: skipped when PARITY=0. Bit value: even = XOR of data; odd = XNOR of data. Computed from the latched word.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT clocks, then back to IDLE.
- Latency: tx falls on the first edge after the accepting edge.
- Frame length: F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
- tx_busy=1 from the edge after acceptance through the last stop-bit clock.
- tx_done=1 for exactly one cycle, the first IDLE cycle after STOP, coincident with tx_ready rising.
- Back-to-back: if tx_valid is held, the next word is accepted in that IDLE cycle. Frame-to-frame period is F+1 clocks, with exactly one idle-high clock between frames.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps on each bit boundary. Bit index wraps to 0 on leaving DATA.
- Reset mid-frame: tx goes to 1 immediately (asynchronous), the frame is abandoned, and no tx_done pulse is produced.

Optional Feature:
- Macro: UART_TX_LED_EN.
- Defined: port led exists and is driven by a down-counter of width $clog2(LED_HOLD_CYCLES+1).
  - Counter loads LED_HOLD_CYCLES on the tx_done cycle; led=1 while counter > 0.
  - A new tx_done reloads the counter (retrigger).
  - Counter resets to 0.
- Undefined: no led port, no counter logic.

Decomposition:
- Package uart_pkg holds:
  - parity constants PARITY_NONE/EVEN/ODD;
  - state typedef tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - function calc_clks_per_bit(clk_freq, baud).
- One sub-module, uart_baud_tick: parametrised counter with enable. Emits a one-cycle bit_end strobe at count CLKS_PER_BIT-1 and clears on disable.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10.
- 8E1, send 0xA5.
  - tx sampled mid-bit reads 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Frame F=110 clocks; tx_done pulses on clock 111 after accept; tx_busy high for 110 clocks.
- 7O2 (DATA_BITS=7, PARITY=2, STOP_BITS=2), send 0x41.
  - Bits read 0, 1,0,0,0,0,0,1, parity 1, stop 1,1; F=110.
- 8N1, tx_valid held with 0x00 then 0xFF.
  - Start bits 101 clocks apart (F=100+1).
  - Exactly one idle-high clock between frames; two tx_done pulses.
- 8E1, rst_n low during data bit 3 of 0x5A.
  - tx=1 in the same cycle as reset assertion; no tx_done.
  - After release: tx_ready=1, and the next frame is correct.
- 8E1, during a frame toggle tx_data to 0xFF and pulse tx_valid.
  - Frame still carries the original word; no extra frame; tx_ready=0 throughout.
- UART_TX_LED_EN defined, LED_HOLD_CYCLES=20.
  - led high for exactly 20 clocks after tx_done.
  - A second frame's done pulse within the hold window restarts the 20-clock count.
